// File: rtl/ft2232h_tx_arb.sv
// Purpose : two-requester packet arbiter feeding the FT2232H synchronous-FIFO write port, with idle send-immediate.
// Latency : IDLE->SENDx in one cycle; a granted byte appears on data_o/wr_n_o on the handshake edge.
// Backpressure: TXE# high freezes the output register and drops ready; packets never interleave.
module ft2232h_tx_arb #(
    parameter int IDLE_FLUSH = 16
) (
    input  logic        clkout_i,
    input  logic        rst_n_i,
    input  logic        txe_i,
    output logic        wr_n_o,
    output logic [7:0]  data_o,
    output logic        siwu_n_o,
    input  logic        req0_valid_i,
    input  logic        req1_valid_i,
    input  logic [7:0]  req0_data_i,
    input  logic [7:0]  req1_data_i,
    input  logic        req0_last_i,
    input  logic        req1_last_i,
    output logic        req0_ready_o,
    output logic        req1_ready_o,
    output logic [1:0]  grant_o,
    output logic [15:0] tx_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND0 = 2'd1,
        ST_SEND1 = 2'd2
    } state_t;

    // The flush pulse fires on the edge where the idle count would step onto IDLE_FLUSH.
    localparam logic [7:0] FLUSH_M1 = 8'(IDLE_FLUSH - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_rst_done;
    logic        r_last_srv;
    logic        r_wr_n;
    logic [7:0]  r_data;
    logic        r_siwu_n;
    logic [15:0] r_tx_count;
    logic        r_dirty;
    logic [7:0]  r_idle_cnt;

    logic        w_free;
    logic        w_accept;
    logic        w_hs0;
    logic        w_hs1;
    logic        w_hs;
    logic [7:0]  w_hs_data;
    logic        w_idle_cond;
    logic        w_flush;

    // Output register can take a new byte when empty or when its byte leaves this edge.
    assign w_free    = r_wr_n | ~txe_i;
    assign w_accept  = ~r_wr_n & ~txe_i;
    assign w_hs0     = req0_ready_o & req0_valid_i;
    assign w_hs1     = req1_ready_o & req1_valid_i;
    assign w_hs      = w_hs0 | w_hs1;
    assign w_hs_data = w_hs1 ? req1_data_i : req0_data_i;

    assign w_idle_cond = (r_state == ST_IDLE) & r_wr_n & ~req0_valid_i & ~req1_valid_i & r_dirty;
    assign w_flush     = w_idle_cond & (r_idle_cnt == FLUSH_M1);

    assign wr_n_o     = r_wr_n;
    assign data_o     = r_data;
    assign siwu_n_o   = r_siwu_n;
    assign tx_count_o = r_tx_count;

    // State register; r_rst_done holds off the first grant until the second edge after reset release.
    always_ff @(posedge clkout_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            r_rst_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rst_done <= 1'b1;
        end
    end

    // Next state: round-robin on ties, owner keeps the bus until its last byte is taken.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_rst_done) begin
                    if (req0_valid_i && req1_valid_i)
                        w_state_nxt = r_last_srv ? ST_SEND0 : ST_SEND1;
                    else if (req0_valid_i)
                        w_state_nxt = ST_SEND0;
                    else if (req1_valid_i)
                        w_state_nxt = ST_SEND1;
                end
            end
            ST_SEND0: if (w_hs0 && req0_last_i) w_state_nxt = ST_IDLE;
            ST_SEND1: if (w_hs1 && req1_last_i) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: grant follows state, ready only for the owner while the output register is free.
    always_comb begin
        grant_o      = 2'b00;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        case (r_state)
            ST_SEND0: begin
                grant_o      = 2'b01;
                req0_ready_o = w_free;
            end
            ST_SEND1: begin
                grant_o      = 2'b10;
                req1_ready_o = w_free;
            end
            default: ;
        endcase
    end

    // Remember who finished a packet last so the other side wins the next tie.
    always_ff @(posedge clkout_i or negedge rst_n_i) begin
        if (!rst_n_i)
            r_last_srv <= 1'b1;
        else if (w_hs0 && req0_last_i)
            r_last_srv <= 1'b0;
        else if (w_hs1 && req1_last_i)
            r_last_srv <= 1'b1;
    end

    // Output byte register: load on handshake, hold while TXE# stalls, otherwise go idle.
    always_ff @(posedge clkout_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_n <= 1'b1;
            r_data <= 8'h00;
        end else if (w_hs) begin
            r_wr_n <= 1'b0;
            r_data <= w_hs_data;
        end else if (w_free) begin
            r_wr_n <= 1'b1;
        end
    end

    // Count bytes the FT2232H actually took; wraps naturally at 16 bits.
    always_ff @(posedge clkout_i or negedge rst_n_i) begin
        if (!rst_n_i)
            r_tx_count <= 16'h0000;
        else if (w_accept)
            r_tx_count <= r_tx_count + 16'h0001;
    end

    // Idle flush: after a quiet period following written data, pulse SIWU# once.
    always_ff @(posedge clkout_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_siwu_n   <= 1'b1;
            r_idle_cnt <= 8'h00;
            r_dirty    <= 1'b0;
        end else begin
            r_siwu_n <= ~w_flush;
            if (w_flush || !w_idle_cond)
                r_idle_cnt <= 8'h00;
            else
                r_idle_cnt <= r_idle_cnt + 8'h01;
            if (w_accept)
                r_dirty <= 1'b1;
            else if (w_flush)
                r_dirty <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ft2232h_tx_arb.sv
// Bench for ft2232h_tx_arb: directed scenarios plus randomized packet traffic against a
// packet-level round-robin model of the expected FT2232H byte stream.
module tb_ft2232h_tx_arb;

    logic        clkout_i = 1'b0;
    logic        rst_n_i;
    logic        txe_i;
    logic        wr_n_o;
    logic [7:0]  data_o;
    logic        siwu_n_o;
    logic        req0_valid_i, req1_valid_i;
    logic [7:0]  req0_data_i, req1_data_i;
    logic        req0_last_i, req1_last_i;
    logic        req0_ready_o, req1_ready_o;
    logic [1:0]  grant_o;
    logic [15:0] tx_count_o;

    always #8 clkout_i = ~clkout_i;

    ft2232h_tx_arb #(.IDLE_FLUSH(16)) dut (
        .clkout_i     (clkout_i),
        .rst_n_i      (rst_n_i),
        .txe_i        (txe_i),
        .wr_n_o       (wr_n_o),
        .data_o       (data_o),
        .siwu_n_o     (siwu_n_o),
        .req0_valid_i (req0_valid_i),
        .req1_valid_i (req1_valid_i),
        .req0_data_i  (req0_data_i),
        .req1_data_i  (req1_data_i),
        .req0_last_i  (req0_last_i),
        .req1_last_i  (req1_last_i),
        .req0_ready_o (req0_ready_o),
        .req1_ready_o (req1_ready_o),
        .grant_o      (grant_o),
        .tx_count_o   (tx_count_o)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Requester byte queues, monitor state, expected stream.
    logic [7:0] q0_dat[$], q1_dat[$];
    bit         q0_last[$], q1_last[$];
    bit         mid0, mid1, hs0, hs1;
    int         gap_pct;
    logic [7:0] obs_q[$], exp_q[$];
    int         acc_cnt, low_cnt, run_len, max_run, siwu_cnt, viol;

    task automatic mon_clear();
        obs_q.delete();
        acc_cnt = 0; low_cnt = 0; run_len = 0; max_run = 0; siwu_cnt = 0; viol = 0;
    endtask

    // One clock: observe at the falling edge, then return just after the rising edge.
    task automatic tick();
        @(negedge clkout_i);
        if (rst_n_i && !wr_n_o && !txe_i) begin
            obs_q.push_back(data_o);
            acc_cnt++;
        end
        if (!wr_n_o) begin
            low_cnt++; run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        if (!siwu_n_o) siwu_cnt++;
        hs0 = req0_valid_i && req0_ready_o;
        hs1 = req1_valid_i && req1_ready_o;
        if (req0_ready_o && grant_o != 2'b01) viol++;
        if (req1_ready_o && grant_o != 2'b10) viol++;
        if (grant_o == 2'b11) viol++;
        @(posedge clkout_i);
        #1;
    endtask

    // Pop bytes taken on the last edge and present the next ones; gaps only inside a packet.
    task automatic drive_update();
        if (hs0 && q0_dat.size() > 0) begin
            mid0 = !q0_last[0];
            void'(q0_dat.pop_front()); void'(q0_last.pop_front());
        end
        if (hs1 && q1_dat.size() > 0) begin
            mid1 = !q1_last[0];
            void'(q1_dat.pop_front()); void'(q1_last.pop_front());
        end
        hs0 = 0; hs1 = 0;
        req0_valid_i = (q0_dat.size() > 0) && !(mid0 && ($urandom_range(99) < gap_pct));
        req1_valid_i = (q1_dat.size() > 0) && !(mid1 && ($urandom_range(99) < gap_pct));
        req0_data_i  = (q0_dat.size() > 0) ? q0_dat[0] : 8'h00;
        req1_data_i  = (q1_dat.size() > 0) ? q1_dat[0] : 8'h00;
        req0_last_i  = (q0_dat.size() > 0) ? q0_last[0] : 1'b0;
        req1_last_i  = (q1_dat.size() > 0) ? q1_last[0] : 1'b0;
    endtask

    task automatic step();
        drive_update();
        tick();
    endtask

    task automatic flush_q();
        q0_dat.delete(); q1_dat.delete(); q0_last.delete(); q1_last.delete();
        mid0 = 0; mid1 = 0; hs0 = 0; hs1 = 0;
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        hs0 = 0; hs1 = 0; mid0 = 0; mid1 = 0;
        drive_update();
        repeat (3) tick();
        rst_n_i = 1'b1;
        mon_clear();
    endtask

    task automatic push_pkt(input int req, input logic [7:0] b[$]);
        foreach (b[i]) begin
            if (req == 0) begin q0_dat.push_back(b[i]); q0_last.push_back(i == b.size() - 1); end
            else          begin q1_dat.push_back(b[i]); q1_last.push_back(i == b.size() - 1); end
        end
    endtask

    task automatic gen_pkts(input int req, input int n);
        logic [7:0] b[$];
        for (int p = 0; p < n; p++) begin
            b.delete();
            for (int k = 0; k < int'($urandom_range(1, 5)); k++) b.push_back(8'($urandom));
            push_pkt(req, b);
        end
    endtask

    // Packet-level model: while both sides have packets they alternate (requester 0 first
    // after reset); once one side runs dry the other sends the rest. Whole packets, no mixing.
    task automatic build_exp();
        int  i0, i1;
        bit  turn, who, done, h0, h1;
        i0 = 0; i1 = 0; turn = 0;
        exp_q.delete();
        while (i0 < q0_dat.size() || i1 < q1_dat.size()) begin
            h0  = i0 < q0_dat.size();
            h1  = i1 < q1_dat.size();
            who = (h0 && h1) ? turn : !h0;
            done = 0;
            if (!who) begin
                while (!done && i0 < q0_dat.size()) begin
                    exp_q.push_back(q0_dat[i0]); done = q0_last[i0]; i0++;
                end
            end else begin
                while (!done && i1 < q1_dat.size()) begin
                    exp_q.push_back(q1_dat[i1]); done = q1_last[i1]; i1++;
                end
            end
            turn = !who;
        end
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_len"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            chk(tag, obs_q[i], exp_q[i]);
    endtask

    task automatic run_until(input string tag, input int target, input int budget);
        int k = 0;
        while (acc_cnt < target && k < budget) begin
            step(); k++;
        end
        chk({tag, "_done"}, k < budget, 1);
    endtask

    initial begin
        int k;
        logic [15:0] cnt0;
        rst_n_i = 1'b0; txe_i = 1'b1; gap_pct = 0;
        req0_valid_i = 0; req1_valid_i = 0; req0_data_i = 0; req1_data_i = 0;
        req0_last_i = 0; req1_last_i = 0;
        mon_clear(); flush_q();

        // Reset values (requester 0 already valid), first-grant timing, 4-byte packet.
        push_pkt(0, '{8'h11, 8'h22, 8'h33, 8'h44});
        build_exp();
        txe_i = 1'b0;
        drive_update();
        repeat (2) tick();
        chk("rst_wr_n", wr_n_o, 1);
        chk("rst_siwu_n", siwu_n_o, 1);
        chk("rst_data", data_o, 8'h00);
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_ready0", req0_ready_o, 0);
        chk("rst_ready1", req1_ready_o, 0);
        chk("rst_tx_count", tx_count_o, 16'h0);
        rst_n_i = 1'b1;
        mon_clear();
        step();
        chk("grant_edge1", grant_o, 2'b00);
        step();
        chk("grant_edge2", grant_o, 2'b01);
        run_until("r031", 4, 30);
        repeat (3) step();
        cmp_stream("r031");
        chk("r031_low_cycles", low_cnt, 4);
        chk("r031_low_run", max_run, 4);
        chk("r031_tx_count", tx_count_o, 16'd4);
        chk("r031_grant", grant_o, 2'b00);

        // Tie from reset alternates whole packets, starting with requester 0.
        flush_q();
        push_pkt(0, '{8'hA0, 8'hA1}); push_pkt(0, '{8'hA0, 8'hA1});
        push_pkt(1, '{8'hB0, 8'hB1}); push_pkt(1, '{8'hB0, 8'hB1});
        build_exp();
        do_reset();
        run_until("r032", 8, 60);
        repeat (2) step();
        cmp_stream("r032");
        chk("r032_third", obs_q.size() > 2 ? obs_q[2] : 8'h00, 8'hB0);

        // TXE# stall holds the pending byte without duplication.
        flush_q();
        txe_i = 1'b1;
        push_pkt(0, '{8'h55, 8'h66});
        build_exp();
        do_reset();
        k = 0;
        while (!(data_o == 8'h55 && !wr_n_o) && k < 10) begin step(); k++; end
        chk("r033_load", k < 10, 1);
        cnt0 = tx_count_o;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("r033_hold_data", data_o, 8'h55);
            chk("r033_hold_wr_n", wr_n_o, 0);
            chk("r033_hold_ready", req0_ready_o, 0);
            chk("r033_hold_count", tx_count_o, cnt0);
        end
        txe_i = 1'b0;
        run_until("r033", 2, 20);
        repeat (3) step();
        cmp_stream("r033");
        chk("r033_tx_count", tx_count_o, 16'd2);

        // Asynchronous reset with byte 33 pending: discarded, never written.
        flush_q();
        txe_i = 1'b0;
        push_pkt(0, '{8'h11, 8'h22, 8'h33, 8'h44});
        do_reset();
        k = 0;
        while (!(data_o == 8'h33 && !wr_n_o) && k < 20) begin step(); k++; end
        chk("r035_load", k < 20, 1);
        txe_i = 1'b1;
        repeat (2) step();
        chk("r035_pending", data_o, 8'h33);
        mon_clear();
        rst_n_i = 1'b0;
        #1;
        chk("r035_wr_n", wr_n_o, 1);
        chk("r035_grant", grant_o, 2'b00);
        chk("r035_tx_count", tx_count_o, 16'h0);
        chk("r035_data", data_o, 8'h00);
        flush_q();
        drive_update();
        txe_i = 1'b0;
        repeat (2) tick();
        rst_n_i = 1'b1;
        repeat (20) step();
        chk("r035_no_write", low_cnt, 0);
        chk("r035_no_accept", obs_q.size(), 0);

        // Send-immediate: one pulse 16 cycles after WR# returns high, none without new data.
        flush_q();
        txe_i = 1'b0;
        push_pkt(0, '{8'h5A});
        do_reset();
        k = 0;
        while (acc_cnt < 1 && k < 20) begin step(); k++; end
        chk("r034_accept", k < 20, 1);
        chk("r034_wr_n_high", wr_n_o, 1);
        repeat (15) step();
        chk("r034_early", siwu_cnt, 0);
        chk("r034_not_yet", siwu_n_o, 1);
        step();
        chk("r034_pulse", siwu_n_o, 0);
        step();
        chk("r034_pulse_end", siwu_n_o, 1);
        repeat (40) step();
        chk("r034_single", siwu_cnt, 1);

        // Valid arriving during the pulse keeps the pulse and is granted next edge.
        push_pkt(0, '{8'h5B});
        k = 0;
        while (acc_cnt < 2 && k < 20) begin step(); k++; end
        chk("r027_accept", k < 20, 1);
        repeat (15) step();
        chk("r027_not_yet", siwu_n_o, 1);
        step();
        chk("r027_pulse", siwu_n_o, 0);
        push_pkt(1, '{8'hC3});
        step();
        chk("r027_pulse_end", siwu_n_o, 1);
        chk("r027_grant", grant_o, 2'b10);
        run_until("r027", 3, 20);
        chk("r027_byte", obs_q[obs_q.size() - 1], 8'hC3);
        chk("r027_pulses", siwu_cnt, 2);

        // Randomized traffic with random TXE# stalls and valid gaps inside packets.
        for (int r = 0; r < 4; r++) begin
            flush_q();
            gen_pkts(0, $urandom_range(1, 8));
            gen_pkts(1, $urandom_range(0, 8));
            build_exp();
            gap_pct = 30;
            txe_i = 1'b0;
            do_reset();
            k = 0;
            while (acc_cnt < exp_q.size() && k < 5000) begin
                txe_i = ($urandom_range(99) < 30);
                step(); k++;
            end
            txe_i = 1'b0;
            repeat (5) step();
            chk("rand_done", k < 5000, 1);
            cmp_stream("rand");
            chk("rand_tx_count", tx_count_o, 16'(exp_q.size()));
            chk("rand_ready_grant", viol, 0);
        end
        gap_pct = 0;

        // Counter wrap: 65535 accepted bytes then one more.
        flush_q();
        txe_i = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            q0_dat.push_back(8'(i));
            q0_last.push_back(i == 65535);
        end
        do_reset();
        run_until("r036_pre", 65535, 70000);
        chk("r036_ffff", tx_count_o, 16'hFFFF);
        run_until("r036_wrap", 65536, 10);
        chk("r036_wrap", tx_count_o, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
